// File: rtl/puf_chain_eval.sv
// Arbiter-PUF chain controller: drives a challenge onto the chain select lines,
// fires the race REPS times and majority-votes the synchronised arbiter decision.
module puf_chain_eval #(
  parameter int STAGES = 32,
  parameter int SETTLE = 8,
  parameter int REPS   = 7,
  localparam int CW    = $clog2(REPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [STAGES-1:0] chal_data,
  input  logic              abort,
  output logic [STAGES-1:0] sel,
  output logic [1:0]        race_din,
  input  logic              arb_in,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_bit,
  output logic [CW-1:0]     resp_conf,
  output logic              busy
);

  localparam int TW = $clog2(SETTLE + 2);
  localparam logic [TW-1:0] PRE_LAST  = TW'(SETTLE - 1);
  // FIRE runs two extra cycles so the last launch has crossed the synchroniser
  localparam logic [TW-1:0] FIRE_LAST = TW'(SETTLE + 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPS - 1);
  localparam logic [CW-1:0] HALF      = CW'(REPS / 2);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_FIRE = 3'd2;
  localparam logic [2:0] S_SAMP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     rep_q, rep_d;
  logic [CW-1:0]     ones_q, ones_d;
  logic [CW-1:0]     ones_inc;
  logic [STAGES-1:0] sel_q, sel_d;
  logic [1:0]        race_q, race_d;
  logic              valid_q, valid_d;
  logic              bit_q, bit_d;
  logic [CW-1:0]     conf_q, conf_d;
  logic              sync1_q, sync2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rep_d    = rep_q;
    ones_d   = ones_q;
    sel_d    = sel_q;
    bit_d    = bit_q;
    conf_d   = conf_q;
    ones_inc = ones_q + CW'(sync2_q);

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (chal_valid && !abort) begin
            sel_d   = chal_data;
            rep_d   = '0;
            ones_d  = '0;
            cnt_d   = '0;
            state_d = S_PRE;
          end
        end
        S_PRE: begin
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_FIRE;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        S_FIRE: begin
          if (cnt_q == FIRE_LAST) begin
            cnt_d   = '0;
            state_d = S_SAMP;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        S_SAMP: begin
          ones_d = ones_inc;
          rep_d  = rep_q + CW'(1);
          if (rep_q == REP_LAST) begin
            bit_d   = (ones_inc > HALF);
            conf_d  = ones_inc;
            state_d = S_DONE;
          end else begin
            state_d = S_PRE;
          end
        end
        S_DONE: begin
          if (resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    race_d  = ((state_d == S_FIRE) || (state_d == S_SAMP)) ? 2'b11 : 2'b00;
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      ones_q  <= '0;
      sel_q   <= '0;
      race_q  <= 2'b00;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      conf_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      ones_q  <= ones_d;
      sel_q   <= sel_d;
      race_q  <= race_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      conf_q  <= conf_d;
      sync1_q <= arb_in;
      sync2_q <= sync1_q;
    end
  end

  assign chal_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign sel        = sel_q;
  assign race_din   = race_q;
  assign resp_valid = valid_q;
  assign resp_bit   = bit_q;
  assign resp_conf  = conf_q;

endmodule
